asic_uart_tx: RTL

- Serial output stage downstream of the ASIC/multi-cycle CPU core.
- Accepts bytes the core stores to its output port, buffers them in a small FIFO, and shifts each one out as an 8N1 UART frame on a single line.
- Lets the core issue bursts of output stores without stalling on serial timing.

---
 rtl/asic_uart_tx.sv | 96 +++++++++
 1 files changed

// File: rtl/asic_uart_tx.sv
// asic_uart_tx: FIFO-buffered 8N1 UART transmitter fed by the core's output-port stores
//   clk        : system clock, all state on rising edge
//   reset      : asynchronous active-low reset
//   wr_en      : core write strobe (push when not full)
//   wr_data    : byte to queue, captured only on an accepted push
//   full       : FIFO holds FIFO_DEPTH entries
//   fifo_count : bytes queued, excluding the one being shifted out
//   busy       : transmitter FSM not idle
//   overflow   : sticky, a write arrived while full (cleared only by reset)
//   tx         : registered serial line, idles high
//   tx_done    : one-cycle pulse on the last cycle of each stop bit
module asic_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [7:0]       wr_data,
  output logic             full,
  output logic [CNT_W-1:0] fifo_count,
  output logic             busy,
  output logic             overflow,
  output logic             tx,
  output logic             tx_done
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;
  logic [1:0]    state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [7:0]    shift;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic          baud_last, push, pop;
  assign baud_last = baud_cnt == BW'(CLKS_PER_BIT - 1);
  assign full      = fifo_count == CNT_W'(FIFO_DEPTH);
  assign push      = wr_en && !full;
  // The head is taken either from idle or at the very end of a stop bit,
  // which is what makes back-to-back frames contiguous.
  assign pop       = (state == IDLE || (state == STOP && baud_last)) && fifo_count != '0;
  assign busy      = state != IDLE;
  assign tx_done   = state == STOP && baud_last;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      shift      <= '0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      tx         <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= (push && !pop) ? fifo_count + 1'b1 :
                    (!push && pop) ? fifo_count - 1'b1 : fifo_count;
      overflow   <= overflow || (wr_en && full);
      // tx follows the state one cycle late so it comes straight from a flop
      tx         <= state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
      baud_cnt   <= (state == IDLE || baud_last) ? '0 : baud_cnt + 1'b1;
      case (state)
        IDLE:
          if (pop) begin
            shift <= mem[rd_ptr];
            state <= START;
          end
        START:
          if (baud_last) begin
            bit_cnt <= '0;
            state   <= DATA;
          end
        DATA:
          if (baud_last) begin
            shift   <= shift >> 1;
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) state <= STOP;
          end
        STOP:
          if (baud_last) begin
            if (pop) shift <= mem[rd_ptr];
            state <= pop ? START : IDLE;
          end
      endcase
    end
  end
endmodule
